// File: rtl/rns_pkg.sv
// Shared constants for the RNS mixed-radix converter: moduli, the inverse
// table m_k^-1 mod m_j, the product helper and the FSM state type.
package rns_pkg;

  localparam int unsigned MAX_CH  = 8;
  localparam int unsigned MAX_K_W = $clog2(MAX_CH);
  localparam int unsigned TAB_W   = 16;

  typedef logic [MAX_CH-1:0][TAB_W-1:0]             mod_tab_t;
  typedef logic [MAX_CH-1:0][MAX_CH-1:0][TAB_W-1:0] inv_tab_t;

  typedef enum logic [1:0] {IDLE, DIGIT, ACCUM, DONE} mrc_state_e;

  // Pairwise-coprime moduli sized for 8-bit channels; index 0 is rightmost.
  localparam mod_tab_t MODULI = {16'd233, 16'd239, 16'd241, 16'd247,
                                 16'd251, 16'd253, 16'd255, 16'd256};

  // Extended Euclid; returns a^-1 mod m, or 0 when no inverse exists.
  function automatic int unsigned inv_mod(input int unsigned a, input int unsigned m);
    int t, nt, r, nr, q, tmp;
    if (m <= 1) return 0;
    t  = 0;
    nt = 1;
    r  = int'(m);
    nr = int'(a % m);
    while (nr != 0) begin
      q   = r / nr;
      tmp = t - q * nt;
      t   = nt;
      nt  = tmp;
      tmp = r - q * nr;
      r   = nr;
      nr  = tmp;
    end
    if (r != 1) return 0;
    if (t < 0) t = t + int'(m);
    return t;
  endfunction

  function automatic inv_tab_t build_inv();
    inv_tab_t tab;
    tab = '0;
    for (int k = 0; k < int'(MAX_CH); k++) begin
      for (int j = 0; j < int'(MAX_CH); j++) begin
        if (k != j) tab[k][j] = TAB_W'(inv_mod(32'(MODULI[k]), 32'(MODULI[j])));
      end
    end
    return tab;
  endfunction

  localparam inv_tab_t INV = build_inv();

  // Dynamic range M of the first n channels.
  function automatic logic [63:0] prod_moduli(input int unsigned n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < int'(MAX_CH); i++) begin
      if (i < int'(n)) p = p * 64'(MODULI[i]);
    end
    return p;
  endfunction

endpackage

// File: rtl/rns_chan_step.sv
// One mixed-radix step for a single channel: ((r - a) mod m) * inv mod m.
module rns_chan_step
  import rns_pkg::*;
#(
  parameter int unsigned CW = 8
) (
  input  logic [CW-1:0] r_i,
  input  logic [CW-1:0] a_i,
  input  logic [CW:0]   m_i,
  input  logic [CW-1:0] inv_i,
  output logic [CW-1:0] r_new_c_o
);

  logic [CW:0]     a_red_c;
  logic [CW:0]     diff_c;
  logic [2*CW-1:0] prod_c;
  logic [2*CW-1:0] rem_c;

  // m and inv are tied to table constants, so the reductions fold to constant-modulus logic.
  always_comb begin
    a_red_c = (CW+1)'(a_i) % m_i;
    if ((CW+1)'(r_i) >= a_red_c) diff_c = (CW+1)'(r_i) - a_red_c;
    else                         diff_c = (CW+1)'(r_i) + m_i - a_red_c;
    prod_c    = (2*CW)'(diff_c) * (2*CW)'(inv_i);
    rem_c     = prod_c % (2*CW)'(m_i);
    r_new_c_o = CW'(rem_c);
  end

endmodule

// File: rtl/rns_mrc_converter.sv
// Iterative RNS-to-binary converter (mixed-radix digits, then Horner).
// Define RNS_SIGNED_OUT_EN to map results into the centred range [-M/2, M/2).
module rns_mrc_converter
  import rns_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CW    = 8,
  parameter int unsigned OUT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N_CH*CW-1:0]   in_rns,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_int,
  output logic                 out_err
);

  localparam int unsigned K_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [K_W-1:0] K_LAST_DIG = K_W'(N_CH - 2);
  localparam logic [K_W-1:0] K_TOP      = K_W'(N_CH - 1);

`ifdef RNS_SIGNED_OUT_EN
  localparam logic [63:0]      M_FULL  = prod_moduli(N_CH);
  localparam logic [63:0]      M_HALF  = (M_FULL + 64'd1) >> 1;
  localparam logic [OUT_W-1:0] NEG_OFS = OUT_W'(64'd0 - M_FULL);
`endif

  mrc_state_e                 state_q, state_d;
  logic [K_W-1:0]             k_q, k_d;
  logic [N_CH-1:0][CW-1:0]    r_q, r_d;
  logic [OUT_W-1:0]           acc_q, acc_d;
  logic                       err_q, err_d;
  logic                       in_ready_q, in_ready_d;
  logic                       out_valid_q, out_valid_d;
  logic [OUT_W-1:0]           out_int_q, out_int_d;
  logic                       out_err_q, out_err_d;

  logic [MAX_K_W-1:0]         k_tab_c;
  logic [CW-1:0]              a_c;
  logic [N_CH-1:0][CW-1:0]    inv_c;
  logic [N_CH-1:0][CW-1:0]    step_c;
  logic [OUT_W-1:0]           horner_c;
  logic [OUT_W-1:0]           res_c;

  assign k_tab_c = MAX_K_W'(k_q);
  assign a_c     = r_q[k_q];

  // Once channel k has been stepped past, r_q[k] holds mixed-radix digit a[k].
  for (genvar j = 0; j < N_CH; j++) begin : g_chan
    assign inv_c[j] = CW'(INV[k_tab_c][j]);
    rns_chan_step #(.CW(CW)) u_step (
      .r_i       (r_q[j]),
      .a_i       (a_c),
      .m_i       ((CW+1)'(MODULI[j])),
      .inv_i     (inv_c[j]),
      .r_new_c_o (step_c[j])
    );
  end

  // Horner step; the first ACCUM cycle just loads the top digit.
  always_comb begin
    horner_c = OUT_W'(r_q[k_q]);
    if (k_q != K_TOP) horner_c = acc_q * OUT_W'(MODULI[k_tab_c]) + OUT_W'(r_q[k_q]);
    res_c = horner_c;
`ifdef RNS_SIGNED_OUT_EN
    if (64'(horner_c) >= M_HALF) res_c = horner_c + NEG_OFS;
`endif
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    r_d       = r_q;
    acc_d     = acc_q;
    err_d     = err_q;
    out_int_d = out_int_q;
    out_err_d = out_err_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          r_d   = in_rns;
          err_d = 1'b0;
          for (int i = 0; i < int'(N_CH); i++) begin
            if ((CW+1)'(in_rns[CW*i +: CW]) >= (CW+1)'(MODULI[i])) err_d = 1'b1;
          end
          k_d     = (N_CH == 1) ? K_TOP : '0;
          state_d = (N_CH == 1) ? ACCUM : DIGIT;
        end
      end
      DIGIT: begin
        for (int j = 0; j < int'(N_CH); j++) begin
          if (K_W'(j) > k_q) r_d[j] = step_c[j];
        end
        if (k_q == K_LAST_DIG) begin
          k_d     = K_TOP;
          state_d = ACCUM;
        end else begin
          k_d = k_q + K_W'(1);
        end
      end
      ACCUM: begin
        acc_d = horner_c;
        if (k_q == '0) begin
          state_d   = DONE;
          out_err_d = err_q;
          out_int_d = err_q ? '0 : res_c;
        end else begin
          k_d = k_q - K_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      r_q         <= '0;
      acc_q       <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_int_q   <= '0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      r_q         <= r_d;
      acc_q       <= acc_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_int_q   <= out_int_d;
      out_err_q   <= out_err_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_int   = out_int_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_rns_mrc_converter.sv
// Scoreboard bench for rns_mrc_converter: 4 channels, moduli 256/255/253/251.
module tb_rns_mrc_converter;

  localparam int unsigned N_CH  = 4;
  localparam int unsigned CW    = 8;
  localparam int unsigned OUT_W = 32;
  localparam longint unsigned M    = 64'd4145475840;
  localparam longint unsigned HALF = (M + 64'd1) / 64'd2;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic [N_CH*CW-1:0]   in_rns = '0;
  logic                 out_valid;
  logic                 out_ready = 1'b0;
  logic [OUT_W-1:0]     out_int;
  logic                 out_err;

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int last_hs = -1;

  typedef struct {
    logic [31:0] v;
    logic        e;
    int          t0;
  } exp_t;
  exp_t sb[$];

  rns_mrc_converter #(.N_CH(N_CH), .CW(CW), .OUT_W(OUT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_rns    (in_rns),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_int   (out_int),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] pack(input longint unsigned x);
    return {8'(x % 251), 8'(x % 253), 8'(x % 255), 8'(x % 256)};
  endfunction

  function automatic logic [31:0] expect_of(input longint unsigned x);
`ifdef RNS_SIGNED_OUT_EN
    if (x >= HALF) return 32'(x + (64'd1 << 32) - M);
`endif
    return 32'(x);
  endfunction

  // Present one word, push its expectation at the accept edge.
  task automatic send(input logic [31:0] w, input logic [31:0] ev, input logic ee,
                      output int t0);
    exp_t e;
    bit   ok;
    ok = 1'b0;
    t0 = -1;
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_rns   = w;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    else begin
      t0   = cyc + 1;
      e.v  = ev;
      e.e  = ee;
      e.t0 = t0;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_rns   = 32'($urandom);
  endtask

  task automatic drain();
    for (int n = 0; n < 100; n++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    chk("drain", 64'(sb.size()), 0);
  endtask

  // Output monitor: latency on rising out_valid, compare on handshake.
  always @(negedge clk) begin : mon
    exp_t e;
    bit   prev_ov;
    if (!rst_n) prev_ov = 1'b0;
    else begin
      if (out_valid && !prev_ov && sb.size() > 0) chk("latency", 64'(cyc - sb[0].t0), 7);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          e = sb.pop_front();
          chk("out_int", 64'(out_int), 64'(e.v));
          chk("out_err", 64'(out_err), 64'(e.e));
          last_hs = cyc + 1;
        end
      end
      prev_ov = out_valid;
    end
  end

  initial begin : main
    int          t0;
    bit          ok;
    bit          seen;
    logic [31:0] held;
    longint unsigned x;
    longint unsigned bnd [6];

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 0);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_int", 64'(out_int), 0);
    chk("rst_out_err", 64'(out_err), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("in_ready_after_rst", 64'(ok), 1);

    out_ready = 1'b1;
    send(32'hF7F1EBE8, 32'd1000, 1'b0, t0);
    send(32'h00000000, 32'd0, 1'b0, t0);
`ifdef RNS_SIGNED_OUT_EN
    send({8'd250, 8'd252, 8'd254, 8'd255}, 32'hFFFFFFFF, 1'b0, t0);
`else
    send({8'd250, 8'd252, 8'd254, 8'd255}, 32'd4145475839, 1'b0, t0);
`endif
    send({8'd252, 8'd241, 8'd235, 8'd232}, 32'd0, 1'b1, t0);

    bnd = '{64'd1, 64'd256, HALF - 64'd1, HALF, M - 64'd2, 64'd123456789};
    foreach (bnd[i]) send(pack(bnd[i]), expect_of(bnd[i]), 1'b0, t0);
    repeat (8) begin
      x = 64'($urandom) % M;
      send(pack(x), expect_of(x), 1'b0, t0);
    end
    drain();

    // Backpressure: five stalled cycles, release on the sixth, next word right after.
    out_ready = 1'b0;
    send(pack(64'd987654321), expect_of(64'd987654321), 1'b0, t0);
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    chk("bp_valid_timeout", 64'(ok), 1);
    held = out_int;
    chk("bp_value", 64'(held), 64'(expect_of(64'd987654321)));
    for (int n = 0; n < 5; n++) begin
      if (n > 0) @(negedge clk);
      chk("bp_out_valid", 64'(out_valid), 1);
      chk("bp_hold", 64'(out_int), 64'(held));
      chk("bp_in_ready", 64'(in_ready), 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(pack(64'd42), expect_of(64'd42), 1'b0, t0);
    chk("b2b_accept", 64'(t0), 64'(last_hs + 1));
    drain();

    // Abort: reset three cycles after accept, no result may appear.
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_rns   = 32'hF7F1EBE8;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("abort_accept", 64'(ok), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 64'(out_valid), 0);
    chk("abort_in_ready", 64'(in_ready), 0);
    chk("abort_out_int", 64'(out_int), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      seen |= out_valid;
    end
    chk("abort_no_result", 64'(seen), 0);
    send(32'hF7F1EBE8, 32'd1000, 1'b0, t0);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
